// File: rtl/ask_uart_tx_core_pkg.sv
// Shared constants for the ASK UART transmit path: modulator codes,
// frame levels and the framing FSM encoding.
package ask_uart_tx_core_pkg;

  localparam logic [1:0] ASK_OFF = 2'b00;
  localparam logic [1:0] ASK_POS = 2'b01;
  localparam logic [1:0] ASK_NEG = 2'b11;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Mark keys the carrier half selected by phase; space turns it off.
  function automatic logic [1:0] ask_code(input logic bit_i, input logic phase_i);
    if (!bit_i) return ASK_OFF;
    return phase_i ? ASK_NEG : ASK_POS;
  endfunction

endpackage

// File: rtl/ask_carrier_gen.sv
// Free-running two-phase carrier: phase toggles every carrier_div clocks,
// independent of bit timing so the tone stays continuous across frames.
module ask_carrier_gen #(
  parameter int carrier_div = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic phase
);

  localparam int            CW       = (carrier_div > 1) ? $clog2(carrier_div) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(carrier_div - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/ask_uart_tx_core.sv
// AXIS byte in, UART framing (start, 8 data LSB-first, stop), on-off keyed
// two-phase carrier out as the 2-bit MULP/MULN code.
module ask_uart_tx_core
  import ask_uart_tx_core_pkg::*;
#(
  parameter int clkdiv_tx   = 1600,
  parameter int carrier_div = 20,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] i_tdata,
  input  logic       i_tvalid,
  output logic       i_tready,
  output logic [1:0] ask_tx,
  output logic       busy,
  output logic       bit_out
);

  localparam int            TW        = $clog2(clkdiv_tx);
  localparam logic [TW-1:0] TMR_LAST  = TW'(clkdiv_tx - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          ready_q, ready_d;
  logic [1:0]    ask_q, ask_d;
  logic          phase, bit_tick, accept, bit_lvl;

  ask_carrier_gen #(.carrier_div(carrier_div)) u_carrier (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .phase (phase)
  );

  assign accept   = ready_q & i_tvalid;
  assign bit_tick = (tmr_q == TMR_LAST);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (state_q != IDLE) tmr_d = bit_tick ? '0 : tmr_q + TW'(1);
    unique case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        shift_d   = i_tdata;
        tmr_d     = '0;
        bit_cnt_d = '0;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: if (bit_tick) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: if (bit_tick) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == STOP_LAST) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d   = IDLE;
      tmr_d     = '0;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    bit_lvl = STOP_LEVEL;
    unique case (state_q)
      START:   bit_lvl = START_LEVEL;
      DATA:    bit_lvl = shift_q[0];
      default: bit_lvl = STOP_LEVEL;
    endcase
  end

  // Looking at state_d lets ready rise on the very first idle clock and
  // fall in the cycle right after a transfer.
  assign ready_d = (state_d == IDLE) & enable & ~clear;
  assign ask_d   = clear ? ASK_OFF : ask_code(bit_lvl, phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b0;
      ask_q     <= ASK_OFF;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      ask_q     <= ask_d;
    end
  end

  assign i_tready = ready_q;
  assign ask_tx   = ask_q;
  assign busy     = (state_q != IDLE);
  assign bit_out  = bit_lvl;

endmodule

// File: tb/tb_ask_uart_tx_core.sv
// Frame scoreboard plus a closed-form carrier model for ask_tx.
module tb_ask_uart_tx_core;
  import ask_uart_tx_core_pkg::*;

  localparam int CLKDIV     = 16;
  localparam int CDIV       = 2;
  localparam int NSTOP      = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + NSTOP;

  logic       clk, rst_n, clear, enable, i_tvalid, i_tready, busy, bit_out;
  logic [7:0] i_tdata;
  logic [1:0] ask_tx;

  int   n_chk, n_fail;
  bit   mon_en;
  logic exp_q[$];

  ask_uart_tx_core #(.clkdiv_tx(CLKDIV), .carrier_div(CDIV), .STOP_BITS(NSTOP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .enable   (enable),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .ask_tx   (ask_tx),
    .busy     (busy),
    .bit_out  (bit_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Carrier phase = (clocks since last reset/clear / CDIV) mod 2.
  int         nclk;
  logic [1:0] exp_ask;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nclk    <= 0;
      exp_ask <= 2'b00;
    end else begin
      exp_ask <= (clear || !bit_out) ? 2'b00 : ((((nclk / CDIV) % 2) != 0) ? 2'b11 : 2'b01);
      nclk    <= clear ? 0 : nclk + 1;
    end
  end

  always @(negedge clk) if (rst_n && mon_en) chk("ask_tx", 32'(ask_tx), 32'(exp_ask));

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) exp_q.push_back(b[i]);
    for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
  endtask

  // Called in the clock-low phase; returns just after the transfer edge.
  task automatic handshake(input logic [7:0] b, input bit hold, output int waited);
    i_tdata  = b;
    i_tvalid = 1'b1;
    waited   = 0;
    while (!i_tready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!i_tready) begin
      chk("hs_timeout", 32'(i_tready), 32'd1);
      i_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) i_tvalid = 1'b0;
  endtask

  task automatic check_frame(input bit exp_rdy);
    logic e;
    @(negedge clk);
    chk("busy_first", 32'(busy), 32'd1);
    chk("rdy_drop", 32'(i_tready), 32'd0);
    repeat (CLKDIV / 2) @(negedge clk);
    for (int s = 0; s < FRAME_BITS; s++) begin
      if (s != 0) repeat (CLKDIV) @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("bit_out", 32'(bit_out), 32'(e));
      end
      chk("busy_mid", 32'(busy), 32'd1);
    end
    repeat (CLKDIV / 2 - 1) @(negedge clk);
    chk("busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_end", 32'(busy), 32'd0);
    chk("bit_idle", 32'(bit_out), 32'd1);
    chk("rdy_idle", 32'(i_tready), 32'(exp_rdy));
  endtask

  task automatic send_frame(input logic [7:0] b);
    int w;
    push_frame(b);
    handshake(b, 1'b0, w);
    check_frame(1'b1);
  endtask

  logic [1:0] idle_pat [8] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};

  initial begin
    int w;
    n_chk = 0; n_fail = 0; mon_en = 0;
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; i_tvalid = 1'b0; i_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ask", 32'(ask_tx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(i_tready), 32'd0);
    chk("rst_bit", 32'(bit_out), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;

    // idle carrier pattern
    @(negedge clk);
    chk("idle_ask0", 32'(ask_tx), 32'd0);
    mon_en = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("idle_ask", 32'(ask_tx), 32'(idle_pat[k]));
      chk("idle_bit", 32'(bit_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    send_frame(8'h55);

    // back-to-back with valid held
    push_frame(8'h00);
    handshake(8'h00, 1'b1, w);
    i_tdata = 8'hFF;
    push_frame(8'hFF);
    check_frame(1'b1);
    handshake(8'hFF, 1'b0, w);
    chk("b2b_gap", 32'(w), 32'd0);
    check_frame(1'b1);

    // backpressure via enable
    enable = 1'b0;
    @(negedge clk);
    i_tdata = 8'hA3; i_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(i_tready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd0);
    end
    enable = 1'b1;
    send_frame(8'hA3);

    // clear during data bit 3 of 0xF0
    handshake(8'hF0, 1'b0, w);
    repeat (70) @(negedge clk);
    chk("pre_clr_bit", 32'(bit_out), 32'd0);
    chk("pre_clr_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_bit", 32'(bit_out), 32'd1);
    chk("clr_rdy", 32'(i_tready), 32'd0);
    chk("clr_ask", 32'(ask_tx), 32'd0);
    @(negedge clk);
    chk("clr_ask_rst", 32'(ask_tx), 32'd1);
    chk("clr_rdy_back", 32'(i_tready), 32'd1);
    send_frame(8'h81);

    // async reset during start bit
    handshake(8'h3C, 1'b0, w);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ask", 32'(ask_tx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdy", 32'(i_tready), 32'd0);
    chk("arst_bit", 32'(bit_out), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
